// File: rtl/cal_pkg.sv
//------------------------------------------------------------------------------
// cal_pkg : shared widths and FSM state encoding for the eye-centre calibrator
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cal_pkg;

    localparam int EYE_W = 99;
    localparam int TAP_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_SNAP   = 3'd4,
        ST_SCAN   = 3'd5,
        ST_DONE   = 3'd6
    } cal_state_t;

endpackage

`default_nettype wire

// File: rtl/eye_run_scan.sv
//------------------------------------------------------------------------------
// eye_run_scan : serial longest-zero-run finder, one map bit per cycle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module eye_run_scan
    import cal_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [TAP_W-1:0] index,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W-1:0] best_len
);

    logic [TAP_W-1:0] run_start;
    logic [TAP_W-1:0] run_len;
    logic [TAP_W-1:0] ext_start;
    logic [TAP_W-1:0] ext_len;

    assign ext_start = (run_len == '0) ? index : run_start;
    assign ext_len   = run_len + TAP_W'(1);

    // Strict '>' keeps the earliest run on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (clear) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (bit_valid) begin
            if (bit_in) begin
                run_len <= '0;
            end else begin
                run_start <= ext_start;
                run_len   <= ext_len;
                if (ext_len > best_len) begin
                    best_start <= ext_start;
                    best_len   <= ext_len;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cal_eye_center.sv
//------------------------------------------------------------------------------
// cal_eye_center : clears, accumulates and scans the sampler eye map, reports
// the centre of the widest stable run. Option macro: CAL_EYE_DCHK_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cal_eye_center
    import cal_pkg::*;
#(
    parameter int ACC_CYCLES = 1024,
    parameter int MIN_WIDTH  = 8
) (
    input  logic             c,
    input  logic             r,
    input  logic             start,
    input  logic [EYE_W-1:0] eye,
    input  logic [5:0]       d,
    output logic             eye_clr,
    output logic             busy,
    output logic             valid,
    output logic [TAP_W-1:0] center,
    output logic [TAP_W-1:0] width,
    output logic             err
);

    localparam logic [15:0] ACC_LAST  = 16'(ACC_CYCLES - 1);
    localparam logic [15:0] SCAN_LAST = 16'(EYE_W - 1);

    cal_state_t       state;
    cal_state_t       state_nxt;
    logic [15:0]      cnt;
    logic [EYE_W-1:0] eye_snap;
    logic [TAP_W-1:0] scan_idx;
    logic [TAP_W-1:0] best_start;
    logic [TAP_W-1:0] best_len;
    logic             fail;

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == 16'd1) state_nxt = ST_ACCUM;
            ST_ACCUM:  if (cnt == ACC_LAST) state_nxt = ST_SNAP;
            ST_SNAP:   state_nxt = ST_SCAN;
            ST_SCAN:   if (cnt == SCAN_LAST) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign eye_clr  = (state == ST_CLEAR);
    assign busy     = (state != ST_IDLE);
    assign scan_idx = cnt[TAP_W-1:0];

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            eye_snap <= '0;
        end else if (state == ST_SNAP) begin
            eye_snap <= eye;
        end
    end

    eye_run_scan u_scan (
        .clk        (c),
        .rst        (r),
        .clear      (state == ST_CLEAR),
        .bit_valid  (state == ST_SCAN),
        .bit_in     (eye_snap[scan_idx]),
        .index      (scan_idx),
        .best_start (best_start),
        .best_len   (best_len)
    );

`ifdef CAL_EYE_DCHK_EN
    logic [5:0] d_snap;

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            d_snap <= '0;
        end else if (state == ST_SNAP) begin
            d_snap <= d;
        end
    end

    // A run as long as the period means no data edge was ever captured.
    assign fail = (best_len < TAP_W'(MIN_WIDTH)) || (d_snap == 6'd0) ||
                  (best_len >= {1'b0, d_snap});
`else
    logic unused_d;
    assign unused_d = ^d;
    assign fail     = (best_len < TAP_W'(MIN_WIDTH));
`endif

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            valid  <= 1'b0;
            center <= '0;
            width  <= '0;
            err    <= 1'b0;
        end else begin
            valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                center <= best_start + (best_len >> 1);
                width  <= best_len;
                err    <= fail;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cal_eye_center.sv
//------------------------------------------------------------------------------
// tb_cal_eye_center : directed bench for cal_eye_center (ACC_CYCLES=16)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cal_eye_center;

    logic        c;
    logic        r;
    logic        start;
    logic [98:0] eye;
    logic [5:0]  d;
    logic        eye_clr;
    logic        busy;
    logic        valid;
    logic [6:0]  center;
    logic [6:0]  width;
    logic        err;

    int checks = 0;
    int errors = 0;

    cal_eye_center #(
        .ACC_CYCLES (16),
        .MIN_WIDTH  (8)
    ) dut (
        .c       (c),
        .r       (r),
        .start   (start),
        .eye     (eye),
        .d       (d),
        .eye_clr (eye_clr),
        .busy    (busy),
        .valid   (valid),
        .center  (center),
        .width   (width),
        .err     (err)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // Launch one calibration; lat = negedges from the start edge until valid.
    task automatic run_cal(input logic [98:0] ev, input logic [5:0] dv, input bit swap,
                           output int lat, output logic clr0, output logic clr1,
                           output logic busy0);
        eye = ev;
        d   = dv;
        @(negedge c);
        start = 1'b1;
        @(posedge c);
        @(negedge c);
        start = 1'b0;
        clr0  = eye_clr;
        busy0 = busy;
        lat   = 0;
        @(negedge c);
        lat  = 1;
        clr1 = eye_clr;
        while (!valid && lat < 1000) begin
            if (swap && lat == 40) eye = '1;
            @(negedge c);
            lat++;
        end
    endtask

    task automatic test_reset;
        r = 1'b1; start = 1'b0; eye = '0; d = 6'd0;
        repeat (3) @(negedge c);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (eye_clr !== 1'b0) begin errors++; $display("FAIL reset_eye_clr got %b exp 0", eye_clr); end
        checks++; if ({center, width, err} !== 15'd0)
            begin errors++; $display("FAIL reset_results got c=%0d w=%0d e=%b exp 0/0/0", center, width, err); end
        r = 1'b0;
        @(negedge c);
    endtask

    task automatic test_all_zero;
        int lat; logic c0, c1, b0;
        run_cal('0, 6'd0, 1'b0, lat, c0, c1, b0);
        checks++; if (lat !== 120)  begin errors++; $display("FAIL zero_latency got %0d exp 120", lat); end
        checks++; if (c0 !== 1'b1)  begin errors++; $display("FAIL zero_clr_in_clear got %b exp 1", c0); end
        checks++; if (c1 !== 1'b0)  begin errors++; $display("FAIL zero_clr_after got %b exp 0", c1); end
        checks++; if (b0 !== 1'b1)  begin errors++; $display("FAIL zero_busy got %b exp 1", b0); end
        checks++; if (center !== 7'd49) begin errors++; $display("FAIL zero_center got %0d exp 49", center); end
        checks++; if (width !== 7'd99)  begin errors++; $display("FAIL zero_width got %0d exp 99", width); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL zero_err got %b exp 0", err); end
        @(negedge c);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL zero_valid_pulse got %b exp 0", valid); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL zero_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_two_bits;
        int lat; logic c0, c1, b0; logic [98:0] ev;
        ev = '0; ev[20] = 1'b1; ev[60] = 1'b1;
        run_cal(ev, 6'd0, 1'b1, lat, c0, c1, b0);
        checks++; if (center !== 7'd40) begin errors++; $display("FAIL two_center got %0d exp 40", center); end
        checks++; if (width !== 7'd39)  begin errors++; $display("FAIL two_width got %0d exp 39", width); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL two_err got %b exp 0", err); end
        repeat (20) @(negedge c);
        checks++; if ({center, width} !== {7'd40, 7'd39})
            begin errors++; $display("FAIL two_hold got c=%0d w=%0d exp 40/39", center, width); end
    endtask

    task automatic test_every_fourth;
        int lat; logic c0, c1, b0; logic [98:0] ev;
        ev = '0;
        for (int i = 0; i < 99; i += 4) ev[i] = 1'b1;
        run_cal(ev, 6'd0, 1'b0, lat, c0, c1, b0);
        checks++; if (width !== 7'd3)  begin errors++; $display("FAIL fourth_width got %0d exp 3", width); end
        checks++; if (center !== 7'd2) begin errors++; $display("FAIL fourth_center got %0d exp 2", center); end
        checks++; if (err !== 1'b1)    begin errors++; $display("FAIL fourth_err got %b exp 1", err); end
    endtask

    task automatic test_all_ones;
        int lat; logic c0, c1, b0;
        run_cal('1, 6'd0, 1'b0, lat, c0, c1, b0);
        checks++; if ({center, width, err} !== {7'd0, 7'd0, 1'b1})
            begin errors++; $display("FAIL ones_result got c=%0d w=%0d e=%b exp 0/0/1", center, width, err); end
    endtask

    task automatic test_dchk;
        int lat; logic c0, c1, b0; logic exp_err;
`ifdef CAL_EYE_DCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_cal('0, 6'd30, 1'b0, lat, c0, c1, b0);
        checks++; if (err !== exp_err) begin errors++; $display("FAIL dchk_err got %b exp %b", err, exp_err); end
        checks++; if (width !== 7'd99) begin errors++; $display("FAIL dchk_width got %0d exp 99", width); end
    endtask

    task automatic test_start_during_accum;
        int n; int pulses; int first;
        eye = '0; d = 6'd0; pulses = 0; first = -1;
        @(negedge c);
        start = 1'b1;
        @(posedge c);
        @(negedge c);
        start = 1'b0;
        for (n = 0; n < 300; n++) begin
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
            if (valid) begin
                pulses++;
                if (first < 0) first = n;
            end
            @(negedge c);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL accum_start_pulses got %0d exp 1", pulses); end
        checks++; if (first !== 120) begin errors++; $display("FAIL accum_start_latency got %0d exp 120", first); end
    endtask

    task automatic test_back_to_back;
        int lat; int gap;
        eye = '0;
        @(negedge c);
        start = 1'b1;
        lat = 0;
        while (!valid && lat < 1000) begin @(negedge c); lat++; end
        @(negedge c);
        start = 1'b0;
        gap = 1;
        while (!valid && gap < 1000) begin @(negedge c); gap++; end
        checks++; if (gap !== 121) begin errors++; $display("FAIL b2b_gap got %0d exp 121", gap); end
        repeat (2) @(negedge c);
    endtask

    task automatic test_abort;
        int lat; logic c0, c1, b0; int pulses; logic [98:0] ev;
        eye = '0;
        @(negedge c);
        start = 1'b1;
        @(posedge c);
        @(negedge c);
        start = 1'b0;
        repeat (30) @(negedge c);
        r = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if ({center, width, err} !== 15'd0)
            begin errors++; $display("FAIL abort_zeroed got c=%0d w=%0d e=%b exp 0/0/0", center, width, err); end
        @(negedge c);
        r = 1'b0;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            if (valid) pulses++;
            @(negedge c);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_valid got %0d exp 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got %b exp 0", busy); end
        ev = '0; ev[20] = 1'b1; ev[60] = 1'b1;
        run_cal(ev, 6'd0, 1'b0, lat, c0, c1, b0);
        checks++; if (lat !== 120) begin errors++; $display("FAIL abort_restart_latency got %0d exp 120", lat); end
        checks++; if (center !== 7'd40) begin errors++; $display("FAIL abort_restart_center got %0d exp 40", center); end
    endtask

    initial begin
        test_reset;
        test_all_zero;
        test_two_bits;
        test_every_fourth;
        test_all_ones;
        test_dchk;
        test_start_during_accum;
        test_back_to_back;
        test_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
